// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the Ej8 sequential multiplier: FSM state encodings
// and the default operand width used by the neighbouring register stages.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-and-add datapath: multiplicand register, accumulator and one WIDTH+1-bit adder.
// acc_next exposes the post-step accumulator so the top can capture the final product on the last step.
module seq_mult_datapath
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // The carry is kept as the top bit of sum and shifted into the accumulator.
  always_comb begin
    addend   = acc[0] ? mcand : '0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned sequential multiplier with start/busy/done handshake; one shift-add step per cycle.
// Holds the FSM, step counter and product register; the arithmetic lives in seq_mult_datapath.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      count;
  logic               last_step;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] acc_next;

  assign last_step = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // busy/done decode only the state register, so no input reaches an output combinationally.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
    load = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    step = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      product <= '0;
    end else if (load) begin
      count <= '0;
    end else if (step) begin
      count <= count + 1'b1;
      if (last_step) product <= acc_next;
    end
  end

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .step     (step),
    .a        (a),
    .b        (b),
    .acc_next (acc_next)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) u_mult8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  seq_multiplier #(.WIDTH(4)) u_mult4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  // lat is the edge (after the accepting edge 0) on which a downstream register captures done.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, output logic [15:0] prod,
                         output int lat, output int busy_cyc, output logic seen, output logic overlap);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_cyc = busy8 ? 1 : 0;
    lat = 0; seen = 1'b0; overlap = 1'b0; prod = '0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) begin
        seen = 1'b1; lat = i + 1; prod = product8;
      end else if (busy8) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy8 !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy8); end
    tests++; if (done8 !== 1'b0) begin failed++; $display("[TB] FAIL reset_done: got %b expected 0", done8); end
    tests++; if (product8 !== 16'd0) begin failed++; $display("[TB] FAIL reset_product: got %0d expected 0", product8); end
    tests++; if (product4 !== 8'd0) begin failed++; $display("[TB] FAIL reset_product4: got %0d expected 0", product4); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat; int bc; logic seen; logic ov;
    run_op8(8'd13, 8'd11, p, lat, bc, seen, ov);
    tests++; if (seen !== 1'b1) begin failed++; $display("[TB] FAIL basic_done_seen: got %b expected 1", seen); end
    tests++; if (p !== 16'd143) begin failed++; $display("[TB] FAIL basic_product: got %0d expected 143", p); end
    tests++; if (lat != 9) begin failed++; $display("[TB] FAIL basic_latency: got %0d expected 9", lat); end
    tests++; if (bc != 8) begin failed++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc); end
    tests++; if (ov !== 1'b0) begin failed++; $display("[TB] FAIL basic_busy_done_overlap: got %b expected 0", ov); end
    @(posedge clk); #1;
    tests++; if (done8 !== 1'b0) begin failed++; $display("[TB] FAIL basic_done_pulse_width: got %b expected 0", done8); end
    tests++; if (product8 !== 16'd143) begin failed++; $display("[TB] FAIL basic_product_hold: got %0d expected 143", product8); end
  endtask

  task automatic test_max();
    logic [15:0] p; int lat; int bc; logic seen; logic ov;
    run_op8(8'd255, 8'd255, p, lat, bc, seen, ov);
    tests++; if (p !== 16'hFE01) begin failed++; $display("[TB] FAIL max_product: got %h expected fe01", p); end
    run_op8(8'd200, 8'd129, p, lat, bc, seen, ov);
    tests++; if (p !== 16'd25800) begin failed++; $display("[TB] FAIL carry_product: got %0d expected 25800", p); end
  endtask

  task automatic test_zero_unit();
    logic [15:0] p; int lat; int bc; logic seen; logic ov;
    run_op8(8'd0, 8'd200, p, lat, bc, seen, ov);
    tests++; if (p !== 16'd0) begin failed++; $display("[TB] FAIL zero_product: got %0d expected 0", p); end
    run_op8(8'd1, 8'd200, p, lat, bc, seen, ov);
    tests++; if (p !== 16'd200) begin failed++; $display("[TB] FAIL unit_product: got %0d expected 200", p); end
  endtask

  task automatic test_ignore_start();
    int dones = 0; logic [15:0] p = '0;
    a8 = 8'd7; b8 = 8'd6; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'd99; b8 = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'd250; b8 = 8'd17;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done8) begin dones++; p = product8; end
    end
    tests++; if (dones != 1) begin failed++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones); end
    tests++; if (p !== 16'd42) begin failed++; $display("[TB] FAIL ignore_product: got %0d expected 42", p); end
    tests++; if (busy8 !== 1'b0) begin failed++; $display("[TB] FAIL ignore_idle_after: got %b expected 0", busy8); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    a8 = 8'd9; b8 = 8'd8; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests++; if (product8 !== 16'd0) begin failed++; $display("[TB] FAIL midreset_product: got %0d expected 0", product8); end
    tests++; if (busy8 !== 1'b0) begin failed++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy8); end
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    tests++; if (dones != 0) begin failed++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    logic seen1 = 1'b0; logic seen2 = 1'b0; int gap = 0;
    logic [15:0] p1 = '0; logic [15:0] p2 = '0;
    a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 40 && !seen1; i++) begin
      @(posedge clk); #1;
      if (done8) begin seen1 = 1'b1; p1 = product8; end
    end
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    gap = 1;
    for (int i = 0; i < 40 && !seen2; i++) begin
      @(posedge clk); #1;
      gap++;
      if (done8) begin seen2 = 1'b1; p2 = product8; end
    end
    tests++; if (p1 !== 16'd25) begin failed++; $display("[TB] FAIL b2b_first_product: got %0d expected 25", p1); end
    tests++; if (p2 !== 16'd81) begin failed++; $display("[TB] FAIL b2b_second_product: got %0d expected 81", p2); end
    tests++; if (gap != 9) begin failed++; $display("[TB] FAIL b2b_spacing: got %0d expected 9", gap); end
  endtask

  task automatic test_width4();
    logic seen = 1'b0; int lat = 0; logic [7:0] p = '0;
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done4) begin seen = 1'b1; lat = i + 1; p = product4; end
    end
    tests++; if (p !== 8'd225) begin failed++; $display("[TB] FAIL w4_product: got %0d expected 225", p); end
    tests++; if (lat != 5) begin failed++; $display("[TB] FAIL w4_latency: got %0d expected 5", lat); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_max();
    test_zero_unit();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
